hi_lo_muldiv_unit: RTL and testbench

//  Sequential HI/LO unit that sits after the ALU. It takes MULT/MULTU/DIV/DIVU/MTHI/MTLO

---
 rtl/hi_lo_muldiv_unit.sv | 260 ++++++++++++++++++++++++++
 tb/tb_hi_lo_muldiv_unit.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hi_lo_muldiv_unit.sv
// hi_lo_muldiv_unit: owns the architectural HI/LO registers and executes
// MULT/MULTU/DIV/DIVU/MTHI/MTLO for the pipeline. Division is a 32-step
// restoring divider on operand magnitudes, followed by a sign-fix cycle.
// Multiply is a registered 32x32 multiplier when HILO_FAST_MULT_EN is defined.
// Otherwise it is a 32-step shift-add with the same sign-fix cycle.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   op_valid, op_code     request strobe and opcode
//                         (0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO)
//   op_a, op_b            rs / rt operands, latched at accept
//   mf_req                MFHI/MFLO in decode
//   op_ready              combinational, = !busy
//   busy, done            registered: op in flight / 1-cycle write pulse
//   stall                 combinational, (mf_req | op_valid) & busy
//   hi_out, lo_out        architectural HI / LO
module hi_lo_muldiv_unit #(
  parameter logic [31:0] DBZ_LO  = 32'hFFFF_FFFF,
  parameter logic [31:0] RST_VAL = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        op_valid,
  input  logic [2:0]  op_code,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        mf_req,
  output logic        op_ready,
  output logic        busy,
  output logic        done,
  output logic        stall,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 5;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  // Registered state; r_p/r_q are the shared 64-bit working pair:
  // multiply: {partial product, multiplier}; divide: {remainder, dividend/quotient}.
  logic [1:0]    r_state, w_state;
  logic          r_busy, w_busy;
  logic          r_done, w_done;
  logic [W-1:0]  r_hi, w_hi;
  logic [W-1:0]  r_lo, w_lo;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [W-1:0]  r_p, w_p;
  logic [W-1:0]  r_q, w_q;
  logic [W-1:0]  r_m, w_m;
  logic [W-1:0]  r_a, w_a;
  logic          r_div, w_div;
  logic          r_neg_q, w_neg_q;
  logic          r_neg_r, w_neg_r;
  logic          r_dbz, w_dbz;

  // Combinational helpers
  logic          w_sgn;
  logic          w_a_neg;
  logic          w_b_neg;
  logic [W-1:0]  w_mag_a;
  logic [W-1:0]  w_mag_b;
  logic [W:0]    w_sum;
  logic [W:0]    w_shift;
  logic          w_ge;
  logic [2*W-1:0] w_mul_mag;
  logic [2*W-1:0] w_mul_res;
  logic [W-1:0]  w_div_q;
  logic [W-1:0]  w_div_r;

  // Signed ops are the even opcodes (MULT, DIV).
  assign w_sgn   = ~op_code[0];
  assign w_a_neg = w_sgn & op_a[W-1];
  assign w_b_neg = w_sgn & op_b[W-1];
  assign w_mag_a = w_a_neg ? (~op_a + 32'd1) : op_a;
  assign w_mag_b = w_b_neg ? (~op_b + 32'd1) : op_b;

  // One shift-add multiply step and one restoring divide step.
  assign w_sum   = {1'b0, r_p} + (r_q[0] ? {1'b0, r_m} : 33'd0);
  assign w_shift = {r_p, r_q[W-1]};
  assign w_ge    = (w_shift >= {1'b0, r_m});

`ifdef HILO_FAST_MULT_EN
  assign w_mul_mag = 64'(r_m) * 64'(r_q);
`else
  assign w_mul_mag = {r_p, r_q};
`endif
  assign w_mul_res = r_neg_q ? (~w_mul_mag + 64'd1) : w_mul_mag;
  assign w_div_q   = r_neg_q ? (~r_q + 32'd1) : r_q;
  assign w_div_r   = r_neg_r ? (~r_p + 32'd1) : r_p;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_hi    <= RST_VAL;
      r_lo    <= RST_VAL;
      r_cnt   <= '0;
      r_p     <= '0;
      r_q     <= '0;
      r_m     <= '0;
      r_a     <= '0;
      r_div   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dbz   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_hi    <= w_hi;
      r_lo    <= w_lo;
      r_cnt   <= w_cnt;
      r_p     <= w_p;
      r_q     <= w_q;
      r_m     <= w_m;
      r_a     <= w_a;
      r_div   <= w_div;
      r_neg_q <= w_neg_q;
      r_neg_r <= w_neg_r;
      r_dbz   <= w_dbz;
    end
  end

  // Next-state and datapath logic
  always_comb begin
    w_state = r_state;
    w_busy  = r_busy;
    w_done  = 1'b0;
    w_hi    = r_hi;
    w_lo    = r_lo;
    w_cnt   = r_cnt;
    w_p     = r_p;
    w_q     = r_q;
    w_m     = r_m;
    w_a     = r_a;
    w_div   = r_div;
    w_neg_q = r_neg_q;
    w_neg_r = r_neg_r;
    w_dbz   = r_dbz;

    case (r_state)
      S_IDLE: begin
        if (op_valid) begin
          case (op_code)
            OP_MULT, OP_MULTU: begin
              w_state = S_MUL;
              w_busy  = 1'b1;
              w_cnt   = '0;
              w_p     = '0;
              w_m     = w_mag_a;
              w_q     = w_mag_b;
              w_div   = 1'b0;
              w_neg_q = w_a_neg ^ w_b_neg;
              w_neg_r = 1'b0;
              w_dbz   = 1'b0;
            end
            OP_DIV, OP_DIVU: begin
              w_state = S_DIV;
              w_busy  = 1'b1;
              w_cnt   = '0;
              w_p     = '0;
              w_m     = w_mag_b;
              w_q     = w_mag_a;
              w_a     = op_a;
              w_div   = 1'b1;
              w_neg_q = w_a_neg ^ w_b_neg;
              w_neg_r = w_a_neg;
              w_dbz   = (op_b == 32'd0);
            end
            OP_MTHI: w_hi = op_a;
            OP_MTLO: w_lo = op_a;
            default: ;
          endcase
        end
      end

      S_MUL: begin
`ifdef HILO_FAST_MULT_EN
        w_hi    = w_mul_res[2*W-1:W];
        w_lo    = w_mul_res[W-1:0];
        w_busy  = 1'b0;
        w_done  = 1'b1;
        w_state = S_IDLE;
`else
        // Shift {sum, multiplier} right by one: product bits fill r_q from the top.
        w_p = w_sum[W:1];
        w_q = {w_sum[0], r_q[W-1:1]};
        if (r_cnt == CW'(W - 1)) begin
          w_cnt   = '0;
          w_state = S_FIX;
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
`endif
      end

      S_DIV: begin
        if (w_ge) begin
          w_p = W'(w_shift - {1'b0, r_m});
          w_q = {r_q[W-2:0], 1'b1};
        end else begin
          w_p = w_shift[W-1:0];
          w_q = {r_q[W-2:0], 1'b0};
        end
        if (r_cnt == CW'(W - 1)) begin
          w_cnt   = '0;
          w_state = S_FIX;
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end

      S_FIX: begin
        if (r_div) begin
          // Divide-by-zero runs the full sequence, then substitutes fixed results.
          if (r_dbz) begin
            w_lo = DBZ_LO;
            w_hi = r_a;
          end else begin
            w_lo = w_div_q;
            w_hi = w_div_r;
          end
        end else begin
          w_hi = w_mul_res[2*W-1:W];
          w_lo = w_mul_res[W-1:0];
        end
        w_busy  = 1'b0;
        w_done  = 1'b1;
        w_state = S_IDLE;
      end

      default: begin
        w_state = S_IDLE;
        w_busy  = 1'b0;
      end
    endcase
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign hi_out   = r_hi;
  assign lo_out   = r_lo;
  assign op_ready = ~r_busy;
  assign stall    = (mf_req | op_valid) & r_busy;

endmodule

// File: tb/tb_hi_lo_muldiv_unit.sv
// Testbench for hi_lo_muldiv_unit: a cycle-level reference model built from the
// arithmetic operators is checked against the DUT on every falling edge. Directed
// vectors with literal results pin the model. Define HILO_FAST_MULT_EN to test
// the single-cycle multiplier build.
module tb_hi_lo_muldiv_unit;

  logic        clk;
  logic        reset_n;
  logic        op_valid;
  logic [2:0]  op_code;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        mf_req;
  logic        op_ready;
  logic        busy;
  logic        done;
  logic        stall;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  int n_total;
  int n_pass;

`ifdef HILO_FAST_MULT_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  hi_lo_muldiv_unit dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .op_valid (op_valid),
    .op_code  (op_code),
    .op_a     (op_a),
    .op_b     (op_b),
    .mf_req   (mf_req),
    .op_ready (op_ready),
    .busy     (busy),
    .done     (done),
    .stall    (stall),
    .hi_out   (hi_out),
    .lo_out   (lo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
  endtask

  // Architectural result of an op: {hi, lo}.
  function automatic logic [63:0] ref_result(input logic [2:0] c, input logic [31:0] a,
                                             input logic [31:0] b);
    longint    sa, sb, sq, sr;
    logic [63:0] u;
    case (c)
      3'd0: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
      end
      3'd1: begin
        u = {32'd0, a} * {32'd0, b};
        return u;
      end
      3'd2: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sq = sa / sb;
        sr = sa % sb;
        return {32'(sr), 32'(sq)};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Cycle-level reference model
  logic [31:0] m_hi, m_lo;
  logic [63:0] m_res;
  logic        m_busy, m_done;
  int          m_left;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_hi   <= 32'd0;
      m_lo   <= 32'd0;
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_left <= 0;
      m_res  <= 64'd0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (m_left == 1) begin
          m_hi   <= m_res[63:32];
          m_lo   <= m_res[31:0];
          m_busy <= 1'b0;
          m_done <= 1'b1;
        end
        m_left <= m_left - 1;
      end else if (op_valid) begin
        if (op_code == 3'd4) m_hi <= op_a;
        else if (op_code == 3'd5) m_lo <= op_a;
        else if (op_code <= 3'd3) begin
          m_res  <= ref_result(op_code, op_a, op_b);
          m_busy <= 1'b1;
          m_left <= (op_code <= 3'd1) ? MUL_LAT : DIV_LAT;
        end
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    chk("busy", 64'(busy), 64'(m_busy));
    chk("done", 64'(done), 64'(m_done));
    chk("op_ready", 64'(op_ready), 64'(!m_busy));
    chk("stall", 64'(stall), 64'((mf_req | op_valid) & m_busy));
    chk("hi_out", 64'(hi_out), 64'(m_hi));
    chk("lo_out", 64'(lo_out), 64'(m_lo));
  end

  typedef struct {
    logic [2:0]  code;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[11];

  // Issue one MUL/DIV op, scramble the operand inputs, wait for done (bounded).
  task automatic issue(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                       output int cycles);
    op_valid = 1'b1;
    op_code  = c;
    op_a     = a;
    op_b     = b;
    @(posedge clk); #2;
    op_valid = 1'b0;
    op_a     = $urandom;
    op_b     = $urandom;
    cycles   = 1;
    while (!done && cycles < 100) begin
      @(posedge clk); #2;
      cycles++;
    end
  endtask

  initial begin
    int   cyc;
    int   lat;
    logic saw_done;
    n_total  = 0;
    n_pass   = 0;
    reset_n  = 1'b0;
    op_valid = 1'b0;
    op_code  = 3'd0;
    op_a     = 32'd0;
    op_b     = 32'd0;
    mf_req   = 1'b0;

    vecs[0]  = '{3'd2, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[1]  = '{3'd3, 32'd7,        32'd0,         32'd7,         32'hFFFF_FFFF};
    vecs[2]  = '{3'd0, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[3]  = '{3'd1, 32'hFFFF_FFFF, 32'd2,        32'd1,         32'hFFFF_FFFE};
    vecs[4]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000};
    vecs[5]  = '{3'd2, 32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vecs[6]  = '{3'd3, 32'd100,      32'd7,         32'd2,         32'd14};
    vecs[7]  = '{3'd2, 32'd7,        32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
    vecs[8]  = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0};
    vecs[9]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1};
    vecs[10] = '{3'd0, 32'd3,        32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FFF1};

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi", 64'(hi_out), 64'd0);
    chk("rst_lo", 64'(lo_out), 64'd0);
    reset_n = 1'b1;
    @(posedge clk); #2;

    // MTHI / MTLO: direct writes, no busy, no done
    op_valid = 1'b1; op_code = 3'd4; op_a = 32'hDEAD_BEEF;
    @(posedge clk); #2;
    op_code = 3'd5; op_a = 32'hCAFE_F00D;
    @(posedge clk); #2;
    op_valid = 1'b0;
    chk("mt_hi", 64'(hi_out), 64'hDEAD_BEEF);
    chk("mt_lo", 64'(lo_out), 64'hCAFE_F00D);
    chk("mt_busy", 64'(busy), 64'd0);
    chk("mt_done", 64'(done), 64'd0);

    // Reserved opcode is a no-op
    op_valid = 1'b1; op_code = 3'd6; op_a = 32'h1111_1111;
    @(posedge clk); #2;
    op_valid = 1'b0;
    chk("rsv_busy", 64'(busy), 64'd0);
    chk("rsv_hi", 64'(hi_out), 64'hDEAD_BEEF);

    // Directed arithmetic vectors with literal results and latency
    foreach (vecs[i]) begin
      issue(vecs[i].code, vecs[i].a, vecs[i].b, cyc);
      lat = (vecs[i].code <= 3'd1) ? MUL_LAT + 1 : DIV_LAT + 1;
      chk($sformatf("lat%0d", i), 64'(cyc), 64'(lat));
      chk($sformatf("hi%0d", i), 64'(hi_out), 64'(vecs[i].hi));
      chk($sformatf("lo%0d", i), 64'(lo_out), 64'(vecs[i].lo));
    end

    // mf_req and a held MTLO during a divide: stalled, then accepted in the done cycle
    op_valid = 1'b1; op_code = 3'd3; op_a = 32'd100; op_b = 32'd7;
    @(posedge clk); #2;
    op_code = 3'd5; op_a = 32'h0000_1234; op_b = 32'd0;
    mf_req  = 1'b1;
    cyc = 1;
    while (!done && cyc < 100) begin
      chk("stall_busy", 64'(stall), 64'd1);
      @(posedge clk); #2;
      cyc++;
    end
    chk("stall_lat", 64'(cyc), 64'(DIV_LAT + 1));
    chk("stall_done", 64'(stall), 64'd0);
    chk("stall_hi_new", 64'(hi_out), 64'd2);
    chk("stall_lo_new", 64'(lo_out), 64'd14);
    @(posedge clk); #2;
    op_valid = 1'b0;
    mf_req   = 1'b0;
    chk("mtlo_after_lo", 64'(lo_out), 64'h0000_1234);
    chk("mtlo_after_hi", 64'(hi_out), 64'd2);

    // Asynchronous reset in the middle of a divide
    op_valid = 1'b1; op_code = 3'd2; op_a = 32'hFFFF_FFF9; op_b = 32'd2;
    @(posedge clk); #2;
    op_valid = 1'b0;
    repeat (9) begin
      @(posedge clk); #2;
    end
    chk("mid_busy_pre", 64'(busy), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_hi", 64'(hi_out), 64'd0);
    chk("mid_rst_lo", 64'(lo_out), 64'd0);
    @(posedge clk); #2;
    reset_n  = 1'b1;
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #2;
      if (done) saw_done = 1'b1;
    end
    chk("no_done_after_rst", 64'(saw_done), 64'd0);
    chk("post_rst_lo", 64'(lo_out), 64'd0);

    // Unit recovers after reset
    issue(3'd1, 32'hFFFF_FFFF, 32'd2, cyc);
    chk("rec_lat", 64'(cyc), 64'(MUL_LAT + 1));
    chk("rec_hi", 64'(hi_out), 64'd1);
    chk("rec_lo", 64'(lo_out), 64'hFFFF_FFFE);

    @(posedge clk); #2;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
